// File: rtl/conv_neuron_update_pipe.sv
// Three-stage neuron update: weight/decay lookup, saturating add, threshold/fire.
// One global stall freezes every stage when the output is held.
module conv_neuron_update_pipe #(
  parameter int CHANNELS    = 2,
  parameter int NEURON_BITS = 9,
  parameter int KERNEL_BITS = 6,
  parameter int KERNEL_SIZE = 3,
  parameter int COORD_BITS  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_we,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE+2)-1:0] cfg_addr,
  input  logic [CHANNELS*NEURON_BITS-1:0] cfg_wdata,
  input  logic in_valid,
  output logic in_ready,
  input  logic [1:0] in_op,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0] in_kpos,
  input  logic [COORD_BITS-1:0] in_x,
  input  logic [COORD_BITS-1:0] in_y,
  input  logic in_last,
  input  logic [CHANNELS*NEURON_BITS-1:0] in_fm,
  output logic out_valid,
  input  logic out_ready,
  output logic [CHANNELS*NEURON_BITS-1:0] out_fm,
  output logic [CHANNELS-1:0] out_spikes,
  output logic [COORD_BITS-1:0] out_x,
  output logic [COORD_BITS-1:0] out_y,
  output logic out_last,
  output logic [1:0] out_op,
  output logic out_kpos_err
);
  localparam int CH = CHANNELS;
  localparam int NB = NEURON_BITS;
  localparam int KB = KERNEL_BITS;
  localparam int KK = KERNEL_SIZE * KERNEL_SIZE;
  localparam int AW = $clog2(KK + 2);
  localparam int PW = $clog2(KK);
  localparam int CB = COORD_BITS;
  localparam logic [1:0] OP_ACC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [AW-1:0] A_THR = AW'(KK);
  localparam logic [AW-1:0] A_DEC = AW'(KK + 1);
  localparam logic signed [NB-1:0] SMAX = {1'b0, {(NB-1){1'b1}}};
  localparam logic signed [NB-1:0] SMIN = {1'b1, {(NB-1){1'b0}}};
  localparam logic signed [NB:0] HI = (NB+1)'(SMAX);
  localparam logic signed [NB:0] LO = (NB+1)'(SMIN);

  logic signed [KB-1:0] r_w [KK][CH];
  logic signed [NB-1:0] r_thr [CH];
  logic signed [NB-1:0] r_dec [CH];
  logic [PW-1:0] w_cidx;

  assign w_cidx = cfg_addr[PW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KK; k++)
        for (int c = 0; c < CH; c++)
          r_w[k][c] <= '0;
      for (int c = 0; c < CH; c++) begin
        r_thr[c] <= SMAX;
        r_dec[c] <= '0;
      end
    end else if (cfg_we) begin
      if (cfg_addr < A_THR) begin
        for (int c = 0; c < CH; c++)
          r_w[w_cidx][c] <= cfg_wdata[c*NB +: KB];
      end else if (cfg_addr == A_THR) begin
        for (int c = 0; c < CH; c++)
          r_thr[c] <= cfg_wdata[c*NB +: NB];
      end else if (cfg_addr == A_DEC) begin
        for (int c = 0; c < CH; c++)
          r_dec[c] <= cfg_wdata[c*NB +: NB];
      end
    end
  end

  logic w_adv;
  assign w_adv = out_ready | ~out_valid;
  assign in_ready = w_adv;

  // S1: addend selection; config is sampled here and travels with the txn
  logic w_kbad;
  logic [PW-1:0] w_kidx;
  logic signed [NB:0] w_add [CH];

  assign w_kbad = ({1'b0, in_kpos} >= (PW+1)'(KK));
  assign w_kidx = w_kbad ? '0 : in_kpos;

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      w_add[c] = '0;
      unique case (1'b1)
        !in_op[1]: if (!w_kbad) w_add[c] = (NB+1)'(r_w[w_kidx][c]);
        in_op == OP_DEC: w_add[c] = (NB+1)'(r_dec[c]);
        default: w_add[c] = '0;
      endcase
    end
  end

  logic r1_v, r1_err, r1_last;
  logic [1:0] r1_op;
  logic [CB-1:0] r1_x, r1_y;
  logic signed [NB-1:0] r1_fm [CH];
  logic signed [NB:0] r1_add [CH];
  logic signed [NB-1:0] r1_thr [CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v <= 1'b0;
      r1_err <= 1'b0;
      r1_last <= 1'b0;
      r1_op <= '0;
      r1_x <= '0;
      r1_y <= '0;
      for (int c = 0; c < CH; c++) begin
        r1_fm[c] <= '0;
        r1_add[c] <= '0;
        r1_thr[c] <= '0;
      end
    end else if (w_adv) begin
      r1_v <= in_valid;
      r1_err <= ~in_op[1] & w_kbad;
      r1_last <= in_last;
      r1_op <= in_op;
      r1_x <= in_x;
      r1_y <= in_y;
      for (int c = 0; c < CH; c++) begin
        r1_fm[c] <= in_fm[c*NB +: NB];
        r1_add[c] <= w_add[c];
        r1_thr[c] <= r_thr[c];
      end
    end
  end

  // S2: widened add then clamp to the signed NB range
  logic signed [NB:0] w_raw [CH];
  logic signed [NB-1:0] w_sum [CH];

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      w_raw[c] = (NB+1)'(r1_fm[c]) + r1_add[c];
      w_sum[c] = w_raw[c][NB-1:0];
      if (w_raw[c] > HI) w_sum[c] = SMAX;
      else if (w_raw[c] < LO) w_sum[c] = SMIN;
    end
  end

  logic r2_v, r2_err, r2_last;
  logic [1:0] r2_op;
  logic [CB-1:0] r2_x, r2_y;
  logic signed [NB-1:0] r2_sum [CH];
  logic signed [NB-1:0] r2_thr [CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v <= 1'b0;
      r2_err <= 1'b0;
      r2_last <= 1'b0;
      r2_op <= '0;
      r2_x <= '0;
      r2_y <= '0;
      for (int c = 0; c < CH; c++) begin
        r2_sum[c] <= '0;
        r2_thr[c] <= '0;
      end
    end else if (w_adv) begin
      r2_v <= r1_v;
      r2_err <= r1_err;
      r2_last <= r1_last;
      r2_op <= r1_op;
      r2_x <= r1_x;
      r2_y <= r1_y;
      for (int c = 0; c < CH; c++) begin
        r2_sum[c] <= w_sum[c];
        r2_thr[c] <= r1_thr[c];
      end
    end
  end

  // S3: fire and reset-to-zero
  logic [CH-1:0] w_spk;
  logic [CH*NB-1:0] w_ofm;

  always_comb begin
    w_spk = '0;
    w_ofm = '0;
    for (int c = 0; c < CH; c++) begin
      w_spk[c] = (r2_op != OP_ACC) && (r2_sum[c] >= r2_thr[c]);
      w_ofm[c*NB +: NB] = w_spk[c] ? '0 : r2_sum[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_fm <= '0;
      out_spikes <= '0;
      out_x <= '0;
      out_y <= '0;
      out_last <= 1'b0;
      out_op <= '0;
      out_kpos_err <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r2_v;
      out_fm <= w_ofm;
      out_spikes <= w_spk;
      out_x <= r2_x;
      out_y <= r2_y;
      out_last <= r2_last;
      out_op <= r2_op;
      out_kpos_err <= r2_err;
    end
  end

endmodule

// File: tb/tb_conv_neuron_update_pipe.sv
// Directed bench for conv_neuron_update_pipe: hand-computed vectors,
// stall/backpressure ordering and asynchronous reset mid-burst.
module tb_conv_neuron_update_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [17:0] cfg_wdata = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] in_op = '0;
  logic [3:0] in_kpos = '0;
  logic [7:0] in_x = '0;
  logic [7:0] in_y = '0;
  logic in_last = 1'b0;
  logic [17:0] in_fm = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [17:0] out_fm;
  logic [1:0] out_spikes;
  logic [7:0] out_x, out_y;
  logic out_last;
  logic [1:0] out_op;
  logic out_kpos_err;

  int n_chk = 0;
  int n_err = 0;

  conv_neuron_update_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_kpos(in_kpos), .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .in_fm(in_fm), .out_valid(out_valid), .out_ready(out_ready),
    .out_fm(out_fm), .out_spikes(out_spikes), .out_x(out_x),
    .out_y(out_y), .out_last(out_last), .out_op(out_op),
    .out_kpos_err(out_kpos_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] pk(input int a, input int b);
    return {b[8:0], a[8:0]};
  endfunction

  task automatic cfgw(input logic [3:0] a, input logic [17:0] d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic txn(input string tag, input logic [1:0] op,
                     input logic [3:0] kp, input logic [17:0] fm,
                     input logic [7:0] x, input logic [17:0] efm,
                     input logic [1:0] espk, input logic eerr);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_op = op;
    in_kpos = kp;
    in_fm = fm;
    in_x = x;
    in_y = x + 8'd1;
    in_last = x[0];
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_fm"}, out_fm, efm);
    chk({tag, "_spk"}, out_spikes, espk);
    chk({tag, "_err"}, out_kpos_err, eerr);
    chk({tag, "_side"}, {out_op, out_last, out_y, out_x},
        {op, x[0], x + 8'd1, x});
  endtask

  logic [17:0] vec [4];
  int sent, got, seen_block, stale;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ovalid", out_valid, 1'b0);
    chk("rst_ofm", out_fm, 18'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_iready", in_ready, 1'b1);

    txn("t1", 2'b11, 4'd0, pk(0, 0), 8'd3, pk(0, 0), 2'b00, 1'b0);

    cfgw(4'd1, pk(2, -1));
    txn("t2", 2'b00, 4'd1, pk(10, 10), 8'd4, pk(12, 9), 2'b00, 1'b0);

    cfgw(4'd0, pk(31, -32));
    txn("t3", 2'b00, 4'd0, pk(250, -250), 8'd5, pk(255, -256), 2'b00, 1'b0);

    cfgw(4'd9, pk(-12, 20));
    cfgw(4'd10, pk(-3, -3));
    cfgw(4'd12, pk(100, 100));
    txn("t4", 2'b10, 4'd0, pk(-5, 22), 8'd6, pk(0, 19), 2'b01, 1'b0);

    // backpressure: four txns against a stalled output
    for (int i = 0; i < 4; i++) vec[i] = pk(i * 7 + 1, -(i + 2));
    sent = 0; got = 0; seen_block = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid = (sent < 4);
      in_op = 2'b00;
      in_kpos = 4'd2;
      in_fm = vec[sent % 4];
      in_x = 8'(sent + 40);
      #1;
      if (in_valid && !in_ready) seen_block = 1;
      if (out_valid && out_ready) begin
        if (got < 4) begin
          chk("t5_fm", out_fm, vec[got]);
          chk("t5_x", out_x, 8'(got + 40));
        end
        got++;
      end
      @(posedge clk);
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_block", seen_block, 1);
    chk("t5_sent", sent, 4);
    chk("t5_count", got, 4);

    // config write racing an accept: first txn keeps the old row
    @(negedge clk);
    out_ready = 1'b1;
    cfg_we = 1'b1;
    cfg_addr = 4'd1;
    cfg_wdata = pk(5, 5);
    in_valid = 1'b1;
    in_op = 2'b00;
    in_kpos = 4'd1;
    in_fm = pk(0, 0);
    @(negedge clk);
    cfg_we = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("cfg_old", out_fm, pk(2, -1));
    @(negedge clk);
    chk("cfg_new", out_fm, pk(5, 5));

    txn("t6", 2'b00, 4'd9, pk(7, -3), 8'd7, pk(7, -3), 2'b00, 1'b1);

    // asynchronous reset with the pipe full and stalled
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_op = 2'b11;
    in_fm = pk(1, 1);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("t6_full", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ov", out_valid, 1'b0);
    chk("t6_rst_ir", in_ready, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("t6_stale", stale, 0);

    txn("t7", 2'b00, 4'd1, pk(10, 10), 8'd8, pk(10, 10), 2'b00, 1'b0);
    txn("t8", 2'b11, 4'd0, pk(255, 254), 8'd9, pk(0, 254), 2'b01, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
